// File: rtl/sd_frame_loader_pkg.sv
// Shared definitions for the SD frame loader.
//   state_e        sequencer states (IDLE, WAIT_READY, ISSUE, READ, NEXT, DONE, ERROR)
//   BYTES_PER_SECTOR / WORDS_PER_SECTOR / CHECKSUM_MOD  transfer and checksum constants
//   checksum_add() modular accumulate used when SD_FRAME_LOADER_CHECKSUM_EN is defined
package sd_frame_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitReady,
        StIssue,
        StRead,
        StNext,
        StDone,
        StError
    } state_e;

    localparam int unsigned BYTES_PER_SECTOR = 512;
    localparam int unsigned WORDS_PER_SECTOR = 256;
    localparam int unsigned CHECKSUM_MOD     = 65521;

    // acc < CHECKSUM_MOD on entry, so the 17-bit sum is at most 131055 and two
    // conditional subtractions always bring it back below the modulus.
    function automatic logic [15:0] checksum_add(input logic [15:0] acc,
                                                 input logic [15:0] word);
        logic [16:0] sum;
        sum = {1'b0, acc} + {1'b0, word};
        if (sum >= 17'(CHECKSUM_MOD)) sum = sum - 17'(CHECKSUM_MOD);
        if (sum >= 17'(CHECKSUM_MOD)) sum = sum - 17'(CHECKSUM_MOD);
        return sum[15:0];
    endfunction

endpackage

// File: rtl/sd_frame_loader_if.sv
// Bus bundle between the frame loader, the SD controller and the frame buffer.
//   SD side : sd_ready, sd_rd, sd_address[31:0], sd_dout[7:0], sd_byte_available
//   FB side : wr_en, wr_addr[ADDR_W-1:0], wr_data[15:0] (RGB565)
//   master  : the loader (drives sd_rd/sd_address and the write port)
//   slave   : the SD controller / frame buffer environment
interface sd_frame_loader_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              sd_ready;
    logic              sd_rd;
    logic [31:0]       sd_address;
    logic [7:0]        sd_dout;
    logic              sd_byte_available;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

    modport master (
        input  sd_ready, sd_dout, sd_byte_available,
        output sd_rd, sd_address, wr_en, wr_addr, wr_data
    );

    modport slave (
        output sd_ready, sd_dout, sd_byte_available,
        input  sd_rd, sd_address, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/sd_frame_loader_byte_pair_packer.sv
// Packs a byte stream into 16-bit big-endian words.
//   clk, reset   clock, synchronous active-high reset
//   clear        drop any half-assembled pair and any pending word_valid
//   data_in      incoming byte, qualified by valid
//   word         last completed word {even byte, odd byte}
//   word_valid   one-cycle pulse, the cycle after the odd byte is accepted
module sd_frame_loader_byte_pair_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  data_in,
    input  logic        valid,
    output logic [15:0] word,
    output logic        word_valid
);
    logic        have_hi_q;
    logic [7:0]  hi_q;
    logic [15:0] word_q;
    logic        word_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            have_hi_q    <= 1'b0;
            hi_q         <= 8'h00;
            word_q       <= 16'h0000;
            word_valid_q <= 1'b0;
        end else if (clear) begin
            have_hi_q    <= 1'b0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            if (valid) begin
                if (have_hi_q) begin
                    word_q       <= {hi_q, data_in};
                    word_valid_q <= 1'b1;
                    have_hi_q    <= 1'b0;
                end else begin
                    hi_q      <= data_in;
                    have_hi_q <= 1'b1;
                end
            end
        end
    end

    assign word       = word_q;
    assign word_valid = word_valid_q;
endmodule

// File: rtl/sd_frame_loader.sv
// Loads one frame (SECTORS_PER_FRAME sectors of 512 bytes) from an SD controller
// into an RGB565 frame buffer, two bytes per word, with a stall timeout.
//   clk, reset           clock, synchronous active-high reset
//   start, base_sector   one-cycle load request and first sector (ignored while busy)
//   bus (master)         SD read handshake and frame-buffer write port
//   busy, done, error    status; done/error hold until the next start or reset
//   checksum             running sum of written words mod 65521
// Optional feature: define SD_FRAME_LOADER_CHECKSUM_EN to build the checksum
// accumulator; otherwise checksum is tied to zero.
module sd_frame_loader
    import sd_frame_loader_pkg::*;
#(
    parameter int unsigned SECTORS_PER_FRAME = 12,
    parameter int unsigned ADDR_W            = 12,
    parameter int unsigned TIMEOUT_CYCLES    = 1000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [31:0]              base_sector,
    sd_frame_loader_if.master        bus,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [15:0]              checksum
);
    localparam int unsigned ByteCntW = $clog2(BYTES_PER_SECTOR);
    localparam int unsigned StallW   = $clog2(TIMEOUT_CYCLES + 1);

    state_e              state_q, state_d;
    logic [31:0]         base_q, base_d;
    logic [31:0]         sector_cnt_q, sector_cnt_d;
    logic [ByteCntW-1:0] byte_cnt_q, byte_cnt_d;
    logic [StallW-1:0]   stall_q, stall_d;
    logic [31:0]         sd_address_q, sd_address_d;
    logic [ADDR_W-1:0]   word_addr_q, word_addr_d;

    logic        start_ok;
    logic        byte_ok;
    logic        last_byte;
    logic        stall_hit;
    logic        enter_error;
    logic        pack_clear;
    logic [15:0] word;
    logic        word_valid;

    assign start_ok  = start && (state_q inside {StIdle, StDone, StError});
    assign byte_ok   = bus.sd_byte_available && (state_q == StRead);
    assign last_byte = byte_ok && (byte_cnt_q == ByteCntW'(2 * WORDS_PER_SECTOR - 1));
    // The counter holds the number of idle cycles already seen, so the
    // TIMEOUT_CYCLES-th idle cycle is the one where it sits at TIMEOUT_CYCLES-1.
    assign stall_hit = (stall_q == StallW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        sector_cnt_d = sector_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        sd_address_d = sd_address_q;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d      = StWaitReady;
                    base_d       = base_sector;
                    sector_cnt_d = '0;
                    byte_cnt_d   = '0;
                end
            end
            StWaitReady: begin
                if (bus.sd_ready) begin
                    state_d      = StIssue;
                    sd_address_d = base_q + sector_cnt_q;
                end else if (stall_hit) begin
                    state_d = StError;
                end
            end
            StIssue: state_d = StRead;
            StRead: begin
                if (byte_ok) begin
                    byte_cnt_d = byte_cnt_q + ByteCntW'(1);
                    if (last_byte) begin
                        state_d      = StNext;
                        sector_cnt_d = sector_cnt_q + 32'd1;
                    end
                end else if (stall_hit) begin
                    state_d = StError;
                end
            end
            StNext: begin
                state_d = (sector_cnt_q == SECTORS_PER_FRAME) ? StDone : StWaitReady;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stall_d = '0;
        if ((state_q == StWaitReady || state_q == StRead) && (state_d == state_q) && !byte_ok) begin
            stall_d = stall_q + StallW'(1);
        end
    end

    always_comb begin
        word_addr_d = word_addr_q;
        if (start_ok) begin
            word_addr_d = '0;
        end else if (word_valid) begin
            word_addr_d = word_addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            base_q       <= '0;
            sector_cnt_q <= '0;
            byte_cnt_q   <= '0;
            stall_q      <= '0;
            sd_address_q <= '0;
            word_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            sector_cnt_q <= sector_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            stall_q      <= stall_d;
            sd_address_q <= sd_address_d;
            word_addr_q  <= word_addr_d;
        end
    end

    assign enter_error = (state_d == StError) && (state_q != StError);
    assign pack_clear  = start_ok || enter_error;

    sd_frame_loader_byte_pair_packer u_byte_pair_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pack_clear),
        .data_in    (bus.sd_dout),
        .valid      (byte_ok),
        .word       (word),
        .word_valid (word_valid)
    );

`ifdef SD_FRAME_LOADER_CHECKSUM_EN
    logic [15:0] checksum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= 16'h0000;
        end else if (start_ok) begin
            checksum_q <= 16'h0000;
        end else if (word_valid) begin
            checksum_q <= checksum_add(checksum_q, word);
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 16'h0000;
`endif

    assign bus.sd_rd      = (state_q == StIssue);
    assign bus.sd_address = sd_address_q;
    assign bus.wr_en      = word_valid;
    assign bus.wr_addr    = word_addr_q;
    assign bus.wr_data    = word;

    assign busy  = state_q inside {StWaitReady, StIssue, StRead, StNext};
    assign done  = (state_q == StDone);
    assign error = (state_q == StError);
endmodule

// File: tb/tb_sd_frame_loader.sv
module tb_sd_frame_loader;
    import sd_frame_loader_pkg::*;

`ifdef SD_FRAME_LOADER_CHECKSUM_EN
    localparam bit CkEn = 1'b1;
`else
    localparam bit CkEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        sel = 1'b0;
    logic        sd_ready = 1'b1;
    logic        sd_byte_available = 1'b0;
    logic [31:0] base_sector = 32'd0;
    logic [7:0]  sd_dout = 8'd0;

    int errors = 0;
    int checks = 0;

    logic [7:0]  img [0:6143];
    logic [11:0] wa_q [$];
    logic [15:0] wd_q [$];
    logic [31:0] ra_q [$];

    always #5 clk = ~clk;

    sd_frame_loader_if #(.ADDR_W(12)) ifa ();
    sd_frame_loader_if #(.ADDR_W(12)) ifb ();

    assign ifa.sd_ready = sd_ready;
    assign ifa.sd_dout = sd_dout;
    assign ifa.sd_byte_available = sd_byte_available;
    assign ifb.sd_ready = sd_ready;
    assign ifb.sd_dout = sd_dout;
    assign ifb.sd_byte_available = sd_byte_available;

    logic        busy_a, done_a, error_a, busy_b, done_b, error_b;
    logic [15:0] checksum_a, checksum_b;
    logic        start_a, start_b;
    assign start_a = start & ~sel;
    assign start_b = start & sel;

    sd_frame_loader #(.SECTORS_PER_FRAME(2), .ADDR_W(12), .TIMEOUT_CYCLES(100)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .base_sector(base_sector), .bus(ifa),
        .busy(busy_a), .done(done_a), .error(error_a), .checksum(checksum_a)
    );

    sd_frame_loader #(.SECTORS_PER_FRAME(12), .ADDR_W(12), .TIMEOUT_CYCLES(100)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .base_sector(base_sector), .bus(ifb),
        .busy(busy_b), .done(done_b), .error(error_b), .checksum(checksum_b)
    );

    logic        m_sd_rd, m_wr_en, m_busy, m_done, m_error;
    logic [31:0] m_sd_address;
    logic [11:0] m_wr_addr;
    logic [15:0] m_wr_data, m_checksum;
    assign m_sd_rd      = sel ? ifb.sd_rd : ifa.sd_rd;
    assign m_wr_en      = sel ? ifb.wr_en : ifa.wr_en;
    assign m_sd_address = sel ? ifb.sd_address : ifa.sd_address;
    assign m_wr_addr    = sel ? ifb.wr_addr : ifa.wr_addr;
    assign m_wr_data    = sel ? ifb.wr_data : ifa.wr_data;
    assign m_busy       = sel ? busy_b : busy_a;
    assign m_done       = sel ? done_b : done_a;
    assign m_error      = sel ? error_b : error_a;
    assign m_checksum   = sel ? checksum_b : checksum_a;

    // Passive monitor of the selected DUT.
    always @(negedge clk) begin
        if (m_wr_en === 1'b1) begin
            wa_q.push_back(m_wr_addr);
            wd_q.push_back(m_wr_data);
        end
        if (m_sd_rd === 1'b1) ra_q.push_back(m_sd_address);
    end

    // Reference: word w of the frame is bytes 2w (high) and 2w+1 (low).
    function automatic logic [15:0] exp_word(input int w);
        return {img[2*w], img[2*w+1]};
    endfunction

    function automatic int exp_checksum(input int n);
        int acc = 0;
        for (int w = 0; w < n; w++) acc = (acc + int'(exp_word(w))) % 65521;
        return CkEn ? acc : 0;
    endfunction

    function automatic int count_bad();
        int bad = 0;
        for (int w = 0; w < wa_q.size(); w++)
            if (wa_q[w] !== 12'(w) || wd_q[w] !== exp_word(w)) bad++;
        return bad;
    endfunction

    function automatic logic [11:0] last_wa();
        return (wa_q.size() > 0) ? wa_q[wa_q.size()-1] : 12'hxxx;
    endfunction

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        ra_q.delete();
    endtask

    task automatic pulse_start(input logic [31:0] b);
        base_sector = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        int n = 0;
        while (m_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (m_done === 1'b1);
    endtask

    // SD controller model: one sd_rd per sector, then 512 bytes with random gaps.
    // Stops after byte_limit bytes (if >= 0); pulses start with new_base at byte start_at.
    task automatic serve(input int n_sectors, input int byte_limit, input int gap_max,
                         input int start_at, input logic [31:0] new_base);
        int sent = 0;
        int waited;
        for (int s = 0; s < n_sectors; s++) begin
            waited = 0;
            while (m_sd_rd !== 1'b1) begin
                @(negedge clk);
                waited++;
                if (waited > 2000) begin
                    checks++;
                    errors++;
                    $display("FAIL serve_sd_rd_wait: sector %0d sd_rd=%b want 1", s, m_sd_rd);
                    return;
                end
            end
            @(negedge clk);
            for (int i = 0; i < 512; i++) begin
                if (byte_limit >= 0 && sent == byte_limit) return;
                repeat ($urandom_range(gap_max, 0)) @(negedge clk);
                sd_dout = img[s*512 + i];
                sd_byte_available = 1'b1;
                if (sent == start_at) begin
                    base_sector = new_base;
                    start = 1'b1;
                end
                @(negedge clk);
                sd_byte_available = 1'b0;
                start = 1'b0;
                sent++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sel = d[0];
            #1;
            checks++;
            if ({m_busy, m_done, m_error, m_sd_rd, m_wr_en} !== 5'b0) begin
                errors++;
                $display("FAIL reset_flags dut%0d: got %b want 00000", d,
                         {m_busy, m_done, m_error, m_sd_rd, m_wr_en});
            end
            checks++;
            if (m_wr_addr !== 12'd0 || m_wr_data !== 16'd0) begin
                errors++;
                $display("FAIL reset_wr dut%0d: addr=%0d data=%h want 0/0000", d, m_wr_addr, m_wr_data);
            end
            checks++;
            if (m_sd_address !== 32'd0) begin
                errors++;
                $display("FAIL reset_sd_address dut%0d: got %0d want 0", d, m_sd_address);
            end
            checks++;
            if (m_checksum !== 16'd0) begin
                errors++;
                $display("FAIL reset_checksum dut%0d: got %0d want 0", d, m_checksum);
            end
        end
        sel = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_frame();
        bit ok;
        sel = 1'b0;
        for (int k = 0; k < 1024; k++) img[k] = k[7:0];
        clear_log();
        pulse_start(32'd100);
        serve(2, -1, 2, -1, 32'd0);
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL frame_done: done=%b want 1", m_done); end
        checks++;
        if (ra_q.size() != 2 || ra_q[0] !== 32'd100 || ra_q[1] !== 32'd101) begin
            errors++;
            $display("FAIL frame_sd_address: %0d reads first=%0d want 2 reads 100,101",
                     ra_q.size(), (ra_q.size() > 0) ? ra_q[0] : 32'hffffffff);
        end
        checks++;
        if (wa_q.size() != 512) begin
            errors++;
            $display("FAIL frame_wr_count: got %0d want 512", wa_q.size());
        end
        checks++;
        if (wa_q.size() == 0 || wa_q[0] !== 12'd0 || wd_q[0] !== 16'h0001) begin
            errors++;
            $display("FAIL frame_first_write: writes=%0d want addr 0 data 0001", wa_q.size());
        end
        checks++;
        if (last_wa() !== 12'd511) begin
            errors++;
            $display("FAIL frame_last_addr: got %0d want 511", last_wa());
        end
        checks++;
        if (count_bad() != 0) begin
            errors++;
            $display("FAIL frame_words: %0d mismatches want 0", count_bad());
        end
        checks++;
        if (m_checksum !== 16'(exp_checksum(512))) begin
            errors++;
            $display("FAIL frame_checksum: got %0d want %0d", m_checksum, exp_checksum(512));
        end
        repeat (5) @(negedge clk);
        checks++;
        if (m_done !== 1'b1 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_hold: done=%b busy=%b want 1/0", m_done, m_busy);
        end
    endtask

    task automatic test_random_frame();
        bit ok;
        logic [31:0] b;
        sel = 1'b0;
        b = $urandom;
        for (int k = 0; k < 1024; k++) img[k] = 8'($urandom);
        clear_log();
        pulse_start(b);
        serve(2, -1, 3, -1, 32'd0);
        wait_done(ok);
        checks++;
        if (!ok || wa_q.size() != 512 || count_bad() != 0) begin
            errors++;
            $display("FAIL random_words: done=%b writes=%0d bad=%0d want 1/512/0",
                     ok, wa_q.size(), count_bad());
        end
        checks++;
        if (ra_q.size() != 2 || ra_q[0] !== b || ra_q[1] !== b + 32'd1) begin
            errors++;
            $display("FAIL random_sd_address: %0d reads want %0d,%0d", ra_q.size(), b, b + 1);
        end
        checks++;
        if (m_checksum !== 16'(exp_checksum(512))) begin
            errors++;
            $display("FAIL random_checksum: got %0d want %0d", m_checksum, exp_checksum(512));
        end
    endtask

    task automatic test_start_ignored();
        bit ok;
        logic [31:0] b1, b2;
        sel = 1'b0;
        b1 = $urandom_range(1000, 0);
        b2 = b1 + 32'd5000;
        clear_log();
        pulse_start(b1);
        serve(2, -1, 1, 100, b2);
        wait_done(ok);
        checks++;
        if (!ok || ra_q.size() != 2 || ra_q[0] !== b1 || ra_q[1] !== b1 + 32'd1) begin
            errors++;
            $display("FAIL busy_start_ignored: done=%b reads=%0d want 1, 2 reads at %0d", ok,
                     ra_q.size(), b1);
        end
        checks++;
        if (wa_q.size() != 512) begin
            errors++;
            $display("FAIL busy_start_writes: got %0d want 512", wa_q.size());
        end
        clear_log();
        pulse_start(b2);
        checks++;
        if (m_done !== 1'b0 || m_busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_done_drop: done=%b busy=%b want 0/1", m_done, m_busy);
        end
        serve(2, -1, 0, -1, 32'd0);
        wait_done(ok);
        checks++;
        if (!ok || ra_q.size() == 0 || ra_q[0] !== b2) begin
            errors++;
            $display("FAIL restart_base: done=%b first read=%0d want %0d", ok,
                     (ra_q.size() > 0) ? ra_q[0] : 32'hffffffff, b2);
        end
    endtask

    task automatic test_checksum();
        bit ok;
        sel = 1'b1;
        for (int k = 0; k < 6144; k++) img[k] = 8'hFF;
        clear_log();
        pulse_start(32'd0);
        serve(12, -1, 0, -1, 32'd0);
        wait_done(ok);
        checks++;
        if (!ok || wa_q.size() != 3072 || count_bad() != 0) begin
            errors++;
            $display("FAIL cks_writes: done=%b writes=%0d bad=%0d want 1/3072/0", ok,
                     wa_q.size(), count_bad());
        end
        checks++;
        if (last_wa() !== 12'd3071) begin
            errors++;
            $display("FAIL cks_last_addr: got %0d want 3071", last_wa());
        end
        checks++;
        if (m_checksum !== (CkEn ? 16'd43008 : 16'd0)) begin
            errors++;
            $display("FAIL cks_value: got %0d want %0d", m_checksum, CkEn ? 43008 : 0);
        end
        sel = 1'b0;
    endtask

    task automatic test_timeout();
        sel = 1'b0;
        for (int k = 0; k < 1024; k++) img[k] = 8'($urandom);
        clear_log();
        pulse_start(32'd7);
        serve(2, 300, 1, -1, 32'd0);
        repeat (99) @(negedge clk);
        checks++;
        if (m_error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: error=%b at 99 cycles want 0", m_error);
        end
        @(negedge clk);
        checks++;
        if (m_error !== 1'b1 || m_busy !== 1'b0 || m_done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_error: error=%b busy=%b done=%b at 100 cycles want 1/0/0",
                     m_error, m_busy, m_done);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (wa_q.size() != 150 || count_bad() != 0) begin
            errors++;
            $display("FAIL timeout_writes: got %0d bad=%0d want 150/0", wa_q.size(), count_bad());
        end
        checks++;
        if (m_error !== 1'b1) begin
            errors++;
            $display("FAIL timeout_hold: error=%b want 1", m_error);
        end
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        sel = 1'b0;
        for (int k = 0; k < 1024; k++) img[k] = 8'($urandom);
        clear_log();
        pulse_start(32'd200);
        serve(1, 40, 0, -1, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (m_busy !== 1'b0 || m_wr_en !== 1'b0 || m_error !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: busy=%b wr_en=%b error=%b want 0/0/0",
                     m_busy, m_wr_en, m_error);
        end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (wa_q.size() != 20) begin
            errors++;
            $display("FAIL midreset_writes: got %0d want 20", wa_q.size());
        end
        clear_log();
        pulse_start(32'd300);
        serve(2, -1, 0, -1, 32'd0);
        wait_done(ok);
        checks++;
        if (!ok || wa_q.size() != 512 || count_bad() != 0 || ra_q.size() == 0 || ra_q[0] !== 32'd300) begin
            errors++;
            $display("FAIL midreset_restart: done=%b writes=%0d bad=%0d want 1/512/0 from addr 0",
                     ok, wa_q.size(), count_bad());
        end
    endtask

    task automatic test_ready_stall();
        bit ok;
        sel = 1'b0;
        sd_ready = 1'b0;
        clear_log();
        pulse_start(32'd500);
        repeat (50) @(negedge clk);
        checks++;
        if (ra_q.size() != 0 || m_busy !== 1'b1 || m_error !== 1'b0) begin
            errors++;
            $display("FAIL stall_no_rd: rd cycles=%0d busy=%b error=%b want 0/1/0",
                     ra_q.size(), m_busy, m_error);
        end
        sd_ready = 1'b1;
        serve(2, -1, 0, -1, 32'd0);
        wait_done(ok);
        checks++;
        if (!ok || ra_q.size() != 2 || ra_q[0] !== 32'd500 || ra_q[1] !== 32'd501) begin
            errors++;
            $display("FAIL stall_rd_once: done=%b rd cycles=%0d want 1, 2 at 500/501",
                     ok, ra_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_random_frame();
        test_start_ignored();
        test_checksum();
        test_timeout();
        test_reset_mid_read();
        test_ready_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
